// File: rtl/mesh_tx_pkg.sv
// Shared types and packet-field geometry for the mesh terminal transmit path.
package mesh_tx_pkg;

  localparam int NJ_W   = 8;
  localparam int ROW_W  = 4;
  localparam int COL_W  = 4;
  localparam int MODE_W = 1;
  localparam int HDR_W  = NJ_W + ROW_W + COL_W + MODE_W;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } tx_state_e;

  typedef enum logic {
    ROW_FIRST = 1'b0,
    COL_FIRST = 1'b1
  } mode_e;

  // Field positions are measured down from the packet MSB.
  function automatic int nj_lsb(input int pckg_sz);
    return pckg_sz - NJ_W;
  endfunction

  function automatic int row_lsb(input int pckg_sz);
    return pckg_sz - NJ_W - ROW_W;
  endfunction

  function automatic int col_lsb(input int pckg_sz);
    return pckg_sz - NJ_W - ROW_W - COL_W;
  endfunction

  function automatic int mode_bit(input int pckg_sz);
    return pckg_sz - HDR_W;
  endfunction

  function automatic int payload_w(input int pckg_sz);
    return pckg_sz - HDR_W;
  endfunction

endpackage

// File: rtl/mesh_tx_fifo.sv
// First-word-fall-through packet buffer: storage array, wrapping pointers, occupancy.
module mesh_tx_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_en_i,
  output logic [W-1:0]               rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en_i) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/mesh_term_tx.sv
// Terminal transmit interface: packet assembly, FIFO control FSM, sent counter.
// Optional MESH_TX_SELF_DROP_EN discards self-addressed requests and pulses drop.
module mesh_term_tx
  import mesh_tx_pkg::*;
#(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  parameter int id_row     = 0,
  parameter int id_column  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_row,
  input  logic [3:0]           in_col,
  input  logic                 in_mode,
  input  logic [pckg_sz-18:0]  in_payload,
  output logic                 pndng,
  output logic [pckg_sz-1:0]   data_out,
  input  logic                 popin,
  output logic [15:0]          sent_cnt,
  output logic                 drop
);

  localparam int CW       = $clog2(fifo_depth) + 1;
  localparam int NJ_LSB   = nj_lsb(pckg_sz);
  localparam int ROW_LSB  = row_lsb(pckg_sz);
  localparam int COL_LSB  = col_lsb(pckg_sz);
  localparam int MODE_BIT = mode_bit(pckg_sz);
  localparam int PAY_W    = payload_w(pckg_sz);

  tx_state_e          state_q, state_d;
  logic [15:0]        sent_cnt_q, sent_cnt_d;
  logic [pckg_sz-1:0] packet;
  logic [pckg_sz-1:0] head_data;
  logic [CW-1:0]      count;
  mode_e              mode;
  logic               accept, wr_en, rd_en, self_addr, unused_self;

  assign mode = mode_e'(in_mode);

  always_comb begin
    packet                          = '0;
    packet[pckg_sz-1:NJ_LSB]        = 8'h00;
    packet[NJ_LSB-1:ROW_LSB]        = in_row;
    packet[ROW_LSB-1:COL_LSB]       = in_col;
    packet[MODE_BIT]                = mode;
    packet[PAY_W-1:0]               = in_payload;
  end

  assign self_addr = (in_row == 4'(id_row)) && (in_col == 4'(id_column));
  assign accept    = in_valid && in_ready;
  assign rd_en     = popin && pndng;

`ifdef MESH_TX_SELF_DROP_EN
  logic drop_q;
  assign unused_self = 1'b0;
  assign wr_en       = accept && !self_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_q <= 1'b0;
    else        drop_q <= accept && self_addr;
  end
  assign drop = drop_q;
`else
  assign unused_self = self_addr;
  assign wr_en       = accept;
  assign drop        = 1'b0;
`endif

  mesh_tx_fifo #(
    .W     (pckg_sz),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst_ni    (reset),
    .wr_en_i   (wr_en),
    .wr_data_i (packet),
    .rd_en_i   (rd_en),
    .rd_data_o (head_data),
    .count_o   (count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (wr_en) state_d = FILLING;
      FILLING: begin
        if (wr_en && !rd_en && count == CW'(fifo_depth - 1))
          state_d = FULL;
        else if (rd_en && !wr_en && count == CW'(1))
          state_d = EMPTY;
      end
      FULL:    if (rd_en) state_d = FILLING;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    sent_cnt_d = sent_cnt_q;
    if (rd_en && sent_cnt_q != 16'hFFFF) sent_cnt_d = sent_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      sent_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sent_cnt_q <= sent_cnt_d;
    end
  end

  assign pndng    = (state_q != EMPTY);
  assign in_ready = (state_q != FULL);
  // Storage is not reset; masking keeps data_out at zero whenever nothing is queued.
  assign data_out = pndng ? head_data : '0;
  assign sent_cnt = sent_cnt_q;

endmodule

// File: tb/tb_mesh_term_tx.sv
// Directed bench for mesh_term_tx: vector table plus multi-cycle corner sequences.
module tb_mesh_term_tx;

  localparam int PW    = 40;
  localparam int DEPTH = 4;
  localparam int PAYW  = PW - 17;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      in_row = '0;
  logic [3:0]      in_col = '0;
  logic            in_mode = 1'b0;
  logic [PAYW-1:0] in_payload = '0;
  logic            pndng;
  logic [PW-1:0]   data_out;
  logic            popin = 1'b0;
  logic [15:0]     sent_cnt;
  logic            drop;

  int checks = 0;
  int errors = 0;

  mesh_term_tx #(
    .pckg_sz    (PW),
    .fifo_depth (DEPTH),
    .id_row     (0),
    .id_column  (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row     (in_row),
    .in_col     (in_col),
    .in_mode    (in_mode),
    .in_payload (in_payload),
    .pndng      (pndng),
    .data_out   (data_out),
    .popin      (popin),
    .sent_cnt   (sent_cnt),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            v;
    logic [3:0]      r;
    logic [3:0]      c;
    logic            m;
    logic [PAYW-1:0] p;
    logic            pop;
    logic            e_pnd;
    logic            e_rdy;
    logic [PW-1:0]   e_data;
    logic [15:0]     e_cnt;
  } vec_t;

  vec_t vt[12];

  function automatic logic [PW-1:0] pkt(input logic [3:0] r, input logic [3:0] c,
                                        input logic m, input logic [PAYW-1:0] p);
    return {8'h00, r, c, m, p};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] r, input logic [3:0] c,
                       input logic m, input logic [PAYW-1:0] p, input logic pop);
    in_valid   = v;
    in_row     = r;
    in_col     = c;
    in_mode    = m;
    in_payload = p;
    popin      = pop;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 1'b0);
    repeat (2) step();
    reset = 1'b1;
    step();
  endtask

  logic [PW-1:0] pa, pb, pc, pd, pe, ps;

  initial begin
    pa = 40'h0023801234;
    pb = pkt(4'h1, 4'h5, 1'b0, 23'h000ABC);
    pc = pkt(4'h7, 4'h0, 1'b1, 23'h7FFFFF);
    pd = pkt(4'hF, 4'hF, 1'b0, 23'h000000);
    pe = pkt(4'h0, 4'h1, 1'b1, 23'h00002A);

    //        v     r     c     m     payload       pop   pnd   rdy   data      cnt
    vt[0]  = '{1'b1, 4'h2, 4'h3, 1'b1, 23'h001234, 1'b0, 1'b1, 1'b1, pa,       16'd0};
    vt[1]  = '{1'b1, 4'h1, 4'h5, 1'b0, 23'h000ABC, 1'b0, 1'b1, 1'b1, pa,       16'd0};
    vt[2]  = '{1'b1, 4'h7, 4'h0, 1'b1, 23'h7FFFFF, 1'b0, 1'b1, 1'b1, pa,       16'd0};
    vt[3]  = '{1'b1, 4'hF, 4'hF, 1'b0, 23'h000000, 1'b0, 1'b1, 1'b0, pa,       16'd0};
    vt[4]  = '{1'b1, 4'h0, 4'h1, 1'b1, 23'h00002A, 1'b0, 1'b1, 1'b0, pa,       16'd0};
    vt[5]  = '{1'b1, 4'h0, 4'h1, 1'b1, 23'h00002A, 1'b1, 1'b1, 1'b1, pb,       16'd1};
    vt[6]  = '{1'b1, 4'h0, 4'h1, 1'b1, 23'h00002A, 1'b0, 1'b1, 1'b0, pb,       16'd1};
    vt[7]  = '{1'b0, 4'h0, 4'h0, 1'b0, 23'h000000, 1'b1, 1'b1, 1'b1, pc,       16'd2};
    vt[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 23'h000000, 1'b1, 1'b1, 1'b1, pd,       16'd3};
    vt[9]  = '{1'b0, 4'h0, 4'h0, 1'b0, 23'h000000, 1'b1, 1'b1, 1'b1, pe,       16'd4};
    vt[10] = '{1'b0, 4'h0, 4'h0, 1'b0, 23'h000000, 1'b1, 1'b0, 1'b1, 40'h0,    16'd5};
    vt[11] = '{1'b0, 4'h0, 4'h0, 1'b0, 23'h000000, 1'b1, 1'b0, 1'b1, 40'h0,    16'd5};

    // Reset values
    do_reset();
    chk("rst_pndng", 64'(pndng), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_cnt", 64'(sent_cnt), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);

    // Fill to full, hold-off, pops with order check
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].v, vt[i].r, vt[i].c, vt[i].m, vt[i].p, vt[i].pop);
      step();
      chk($sformatf("vec%0d_pndng", i), 64'(pndng), 64'(vt[i].e_pnd));
      chk($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(vt[i].e_rdy));
      chk($sformatf("vec%0d_data", i), 64'(data_out), 64'(vt[i].e_data));
      chk($sformatf("vec%0d_cnt", i), 64'(sent_cnt), 64'(vt[i].e_cnt));
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 1'b0);

    // Streaming push+pop across pointer wrap
    do_reset();
    drive(1'b1, 4'h1, 4'h0, 1'b0, 23'h0, 1'b0);
    step();
    chk("stream_first", 64'(data_out), 64'(pkt(4'h1, 4'h0, 1'b0, 23'h0)));
    for (int i = 1; i <= 20; i++) begin
      ps = pkt(4'((i % 15) + 1), 4'((i * 3) % 16), 1'(i % 2), 23'(i * 'h111));
      drive(1'b1, 4'((i % 15) + 1), 4'((i * 3) % 16), 1'(i % 2), 23'(i * 'h111), 1'b1);
      step();
      chk($sformatf("stream%0d_data", i), 64'(data_out), 64'(ps));
      chk($sformatf("stream%0d_pndng", i), 64'(pndng), 64'd1);
      chk($sformatf("stream%0d_ready", i), 64'(in_ready), 64'd1);
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 1'b0);
    step();
    chk("stream_cnt", 64'(sent_cnt), 64'd20);

    // Two more pushes -> 3 queued, then asynchronous reset
    drive(1'b1, 4'h3, 4'h3, 1'b0, 23'h11, 1'b0);
    step();
    step();
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 1'b0);
    chk("pre_rst_pndng", 64'(pndng), 64'd1);
    chk("pre_rst_ready", 64'(in_ready), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_pndng", 64'(pndng), 64'd0);
    chk("async_rst_cnt", 64'(sent_cnt), 64'd0);
    chk("async_rst_data", 64'(data_out), 64'd0);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_pndng", 64'(pndng), 64'd0);
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_cnt", 64'(sent_cnt), 64'd0);

    // popin while empty is ignored
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 1'b1);
      step();
      chk($sformatf("empty_pop%0d_pndng", i), 64'(pndng), 64'd0);
      chk($sformatf("empty_pop%0d_cnt", i), 64'(sent_cnt), 64'd0);
    end
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 1'b0);

    // Self-addressed request
    drive(1'b1, 4'h0, 4'h0, 1'b0, 23'h55, 1'b0);
    step();
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 1'b0);
`ifdef MESH_TX_SELF_DROP_EN
    chk("self_drop_pulse", 64'(drop), 64'd1);
    chk("self_drop_pndng", 64'(pndng), 64'd0);
    chk("self_drop_ready", 64'(in_ready), 64'd1);
    step();
    chk("self_drop_end", 64'(drop), 64'd0);
    chk("self_drop_pndng2", 64'(pndng), 64'd0);
`else
    chk("self_q_pndng", 64'(pndng), 64'd1);
    chk("self_q_data", 64'(data_out), 64'(pkt(4'h0, 4'h0, 1'b0, 23'h55)));
    chk("self_q_drop", 64'(drop), 64'd0);
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 1'b1);
    step();
    drive(1'b0, 4'h0, 4'h0, 1'b0, '0, 1'b0);
    chk("self_q_popped", 64'(pndng), 64'd0);
    chk("self_q_cnt", 64'(sent_cnt), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesh_term_tx.md
# mesh_term_tx

Terminal-side transmit interface for the mesh router. It accepts transfer requests from a local source: target row/col, routing mode and payload. It assembles each request into a `pckg_sz`-bit packet and buffers it in a first-word-fall-through FIFO. It presents packets to a router's terminal input port through the `pndng` / `data_out` / `popin` handshake. One instance sits directly upstream of each external terminal port of `mesh_gnrtr`.

## Interface
Parameters:
- `pckg_sz`, 40: packet width in bits; must be ≥ 26.
- `fifo_depth`, 4: buffer entries; power of two, ≥ 2.
- `id_row`, 0: row coordinate of the attached terminal.
- `id_column`, 0: column coordinate of the attached terminal.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: request present.
- `in_ready`, out, 1: request accepted at this edge when high together with `in_valid`.
- `in_row`, in, 4: target row.
- `in_col`, in, 4: target column.
- `in_mode`, in, 1: 0 = row-first routing, 1 = column-first routing.
- `in_payload`, in, `pckg_sz-17`: payload.
- `pndng`, out, 1: head packet available to the router.
- `data_out`, out, `pckg_sz`: head packet; connects to the router's `data_out_i_in`.
- `popin`, in, 1: router consumes the head packet at this edge.
- `sent_cnt`, out, 16: packets popped since reset; saturates at 16'hFFFF.
- `drop`, out, 1: one-cycle pulse when a request is discarded (see Configuration).

## Operation
- Packet layout, MSB first:
  - `[pckg_sz-1 : pckg_sz-8]` = next-jump, written 8'h00.
  - `[pckg_sz-9 : pckg_sz-12]` = `in_row`.
  - `[pckg_sz-13 : pckg_sz-16]` = `in_col`.
  - `[pckg_sz-17]` = `in_mode`.
  - `[pckg_sz-18 : 0]` = `in_payload` (lower `pckg_sz-17` bits of the payload field).
- Push: `in_valid && in_ready` writes the assembled packet at the tail.
- `in_ready` = !full. It does not look ahead on a same-cycle pop.
- Pop: `popin && pndng` advances the head and increments `sent_cnt`.
- `popin` while empty is ignored; no counter change.
- Simultaneous push and pop when neither full nor empty: both take effect; occupancy unchanged.
- Push while full cannot occur (`in_ready` low).
- Pop while full, no push: occupancy drops; `in_ready` rises the next cycle.
- Pointers are `$clog2(fifo_depth)` bits and wrap modulo `fifo_depth`.
- Occupancy count is `$clog2(fifo_depth)+1` bits.
- `data_out` is stable and `pndng` stays high from the cycle the head is valid until the edge where `popin` is sampled.
- Controller states:
  - EMPTY → FILLING on push.
  - FILLING → FULL when occupancy reaches `fifo_depth`.
  - FILLING → EMPTY when the last entry is popped.
  - FULL → FILLING on pop.
  - `pndng` = (state != EMPTY).
  - `in_ready` = (state != FULL).
- Reset asserted mid-operation: all buffered packets are discarded immediately, with no partial pop.

## Timing
- Reset values: `pndng`=0, `in_ready`=1, `data_out`=0, `sent_cnt`=0, `drop`=0, pointers=0, state=EMPTY.
- Push-to-`pndng` latency is 1 cycle: a push sampled at edge N gives `pndng`=1 and a valid `data_out` after edge N.
- Pop effect is visible after the sampling edge:
  - the next head appears on `data_out` in the same cycle;
  - or `pndng` drops if the FIFO is now empty.
- `drop` is registered: high for exactly the cycle after the discarding edge.
- `sent_cnt` updates 1 cycle after the pop edge.

## Configuration
- `MESH_TX_SELF_DROP_EN` defined: a request with `in_row==id_row && in_col==id_column` is accepted (`in_ready` handshake completes) but not written, and `drop` pulses.
- Macro undefined: self-addressed requests are queued like any other; `drop` is tied 0.

## Structure
- Package `mesh_tx_pkg`:
  - field offset/width localparams, derived from `pckg_sz`;
  - `tx_state_e` enum (EMPTY, FILLING, FULL);
  - `mode_e` (ROW_FIRST=0, COL_FIRST=1).
- Sub-module `mesh_tx_fifo`: FWFT storage, pointers and occupancy.
- The top level holds packet assembly, the state decode, the self-drop filter and `sent_cnt`.

## Test plan
- Reset held low, then released: `pndng`=0, `in_ready`=1, `sent_cnt`=0. Push row 2, col 3, mode 1, payload 'h1234: the next cycle `pndng`=1 and `data_out`=0x00_2_3_1_…1234 per the layout.
- Push 4 packets with no pop: `in_ready`=0 after the 4th. A 5th `in_valid` is held off. Pop once: `in_ready`=1 the next cycle; order is preserved.
- Continuous push and pop every cycle for 20 packets: occupancy stays 1; `sent_cnt`=20; no loss or reorder across pointer wrap.
- `popin` pulses while empty: no state change; `sent_cnt` stays 0.
- Reset asserted with 3 packets queued: `pndng` drops asynchronously. After release, the FIFO is empty and `sent_cnt`=0.
- Self-addressed request (row 0, col 0 at `id_row`=`id_column`=0):
  - with `MESH_TX_SELF_DROP_EN`: `drop` pulses and `pndng` stays 0;
  - without it: the packet is queued.
